// File: rtl/mbed_cmd_sequencer.sv
// Command front-end between the MBED GPIO strobes and the dispensing-servo PWM stage:
// synchronise, debounce, queue token requests and sequence colour/dispense commands.
module mbed_cmd_sequencer #(
    parameter int DEBOUNCE_TICKS     = 50000,
    parameter int CNT_W              = 4,
    parameter int QUEUE_MAX          = 15,
    parameter int ACK_TICKS          = 1000,
    parameter int COLOR_SETTLE_TICKS = 25000000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mbed_go,
    input  logic             mbed_color_stb,
    input  logic [1:0]       mbed_color,
    input  logic             disp_busy,
    output logic             go,
    output logic             color_go,
    output logic [1:0]       color_pos,
    output logic [CNT_W-1:0] pending,
    output logic             overflow,
    output logic             ack_err,
    output logic [2:0]       state_dbg
);

    // Handshake: go is a one-cycle request issued only from idle with disp_busy low; the PWM
    // stage acknowledges by raising disp_busy within ACK_TICKS and completes by dropping it.

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ISSUE_GO    = 3'd1,
        S_WAIT_ACK    = 3'd2,
        S_WAIT_DONE   = 3'd3,
        S_ISSUE_COLOR = 3'd4,
        S_COLOR_HOLD  = 3'd5
    } state_t;

    localparam int DB_W   = $clog2(DEBOUNCE_TICKS + 1);
    localparam int ACK_W  = $clog2(ACK_TICKS + 1);
    localparam int HOLD_W = $clog2(COLOR_SETTLE_TICKS + 1);

    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
    localparam logic [ACK_W-1:0]  ACK_LAST  = ACK_W'(ACK_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(COLOR_SETTLE_TICKS - 1);
    localparam logic [CNT_W-1:0]  Q_MAX     = CNT_W'(QUEUE_MAX);

    // Bit 0 carries the go line, bit 1 the colour strobe.
    logic [1:0]      sync1, sync2;
    logic [1:0]      col_s1, col_s2;
    logic [1:0]      deb, deb_q, rise;
    logic [DB_W-1:0] db_cnt [2];

    state_t            state;
    logic [1:0]        color_req;
    logic              color_pend;
    logic [ACK_W-1:0]  ack_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              go_req, color_stb;
    logic              launch_go, launch_color;

    assign state_dbg = state;
    assign go_req    = rise[0];
    assign color_stb = rise[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            sync2  <= '0;
            col_s1 <= '0;
            col_s2 <= '0;
        end else begin
            sync1  <= {mbed_color_stb, mbed_go};
            sync2  <= sync1;
            col_s1 <= mbed_color;
            col_s2 <= col_s1;
        end
    end

    // A level flips only after DEBOUNCE_TICKS consecutive disagreeing samples; the rising
    // edge is registered so each request reaches the queue logic as a clean one-cycle pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb   <= '0;
            deb_q <= '0;
            rise  <= '0;
            for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
        end else begin
            deb_q <= deb;
            rise  <= deb & ~deb_q;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    deb[i]    <= ~deb[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    always_comb begin
        launch_color = 1'b0;
        launch_go    = 1'b0;
        if (state == S_IDLE && !disp_busy) begin
            launch_color = color_pend;
            launch_go    = !color_pend && (pending != '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            go         <= 1'b0;
            color_go   <= 1'b0;
            color_pos  <= '0;
            color_req  <= '0;
            color_pend <= 1'b0;
            pending    <= '0;
            overflow   <= 1'b0;
            ack_err    <= 1'b0;
            ack_cnt    <= '0;
            hold_cnt   <= '0;
        end else begin
            go       <= 1'b0;
            color_go <= 1'b0;

            // A request coinciding with an issue nets out and can never overflow.
            if (go_req && !launch_go) begin
                if (pending == Q_MAX) overflow <= 1'b1;
                else                  pending  <= pending + CNT_W'(1);
            end else if (!go_req && launch_go) begin
                pending <= pending - CNT_W'(1);
            end

            // A fresh strobe wins over the clear so a request landing on issue is not lost.
            if (color_stb) begin
                color_req  <= col_s2;
                color_pend <= 1'b1;
            end else if (launch_color) begin
                color_pend <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    if (launch_color) begin
                        state     <= S_ISSUE_COLOR;
                        color_go  <= 1'b1;
                        color_pos <= color_req;
                    end else if (launch_go) begin
                        state <= S_ISSUE_GO;
                        go    <= 1'b1;
                    end
                end
                S_ISSUE_GO: begin
                    ack_cnt <= '0;
                    state   <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (disp_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (ack_cnt == ACK_LAST) begin
                        ack_err <= 1'b1;
                        state   <= S_IDLE;
                    end else begin
                        ack_cnt <= ack_cnt + ACK_W'(1);
                    end
                end
                S_WAIT_DONE: begin
                    if (!disp_busy) state <= S_IDLE;
                end
                S_ISSUE_COLOR: begin
                    // The issue cycle is the first tick of the settle window.
                    hold_cnt <= HOLD_W'(1);
                    state    <= S_COLOR_HOLD;
                end
                S_COLOR_HOLD: begin
                    if (hold_cnt >= HOLD_LAST) state    <= S_IDLE;
                    else                       hold_cnt <= hold_cnt + HOLD_W'(1);
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mbed_cmd_sequencer.sv
// Self-checking bench for mbed_cmd_sequencer: directed scenarios plus randomized rounds
// scored against an event-level model of queue, overflow and colour-before-token ordering.
module tb_mbed_cmd_sequencer;

  localparam int DEB    = 4;
  localparam int ACK    = 8;
  localparam int SETTLE = 10;
  localparam int QMAX   = 3;
  localparam int CW     = 4;
  localparam int IDLE_CODE = 0;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          mbed_go, mbed_color_stb;
  logic [1:0]    mbed_color;
  logic          disp_busy, busy_drv, busy_resp, resp_en;
  int            resp_dur;
  logic          go, color_go, overflow, ack_err;
  logic [1:0]    color_pos;
  logic [CW-1:0] pending;
  logic [2:0]    state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];
  logic [2:0] act_q[$];
  logic go_prev = 1'b0;
  logic cg_prev = 1'b0;

  assign disp_busy = resp_en ? busy_resp : busy_drv;

  mbed_cmd_sequencer #(
    .DEBOUNCE_TICKS(DEB), .CNT_W(CW), .QUEUE_MAX(QMAX),
    .ACK_TICKS(ACK), .COLOR_SETTLE_TICKS(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .mbed_go(mbed_go), .mbed_color_stb(mbed_color_stb),
    .mbed_color(mbed_color), .disp_busy(disp_busy), .go(go), .color_go(color_go),
    .color_pos(color_pos), .pending(pending), .overflow(overflow), .ack_err(ack_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Event monitor: go -> 3'b000, color_go -> {1, color_pos}; pulses must be lone and 1 wide.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (go) begin
          check("go_excl", 32'({go_prev, color_go}), 32'd0);
          act_q.push_back(3'b000);
        end
        if (color_go) begin
          check("cgo_excl", 32'({cg_prev, go}), 32'd0);
          act_q.push_back({1'b1, color_pos});
        end
      end
      go_prev = go;
      cg_prev = color_go;
    end
  end

  // PWM-stage responder: busy rises the cycle after go and holds resp_dur cycles.
  initial begin
    busy_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (resp_en && go) begin
        @(negedge clk);
        busy_resp = 1'b1;
        repeat (resp_dur) @(negedge clk);
        busy_resp = 1'b0;
      end
    end
  end

  // driver tasks
  task automatic pulse_go(input int hi, input int lo);
    mbed_go = 1'b1;
    repeat (hi) @(negedge clk);
    mbed_go = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_strobe(input logic [1:0] c, input int hi, input int lo);
    mbed_color = c;
    mbed_color_stb = 1'b1;
    repeat (hi) @(negedge clk);
    mbed_color_stb = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  // Counts active edges until the selected output is seen high (0 go, 1 color_go, 2 ack_err);
  // returns -1 when the budget runs out.
  task automatic edges_until(input int which, input int max, output int n);
    logic hit;
    n = 0;
    while (n < max) begin
      @(posedge clk);
      #1;
      n++;
      hit = (which == 0) ? go : (which == 1) ? color_go : ack_err;
      if (hit) return;
    end
    n = -1;
  endtask

  task automatic sb_drain(input string tag);
    check({tag, "_count"}, 32'(act_q.size()), 32'(exp_q.size()));
    while (exp_q.size() > 0 && act_q.size() > 0)
      check({tag, "_event"}, 32'(act_q.pop_front()), 32'(exp_q.pop_front()));
    exp_q.delete();
    act_q.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_go"}, 32'(go), 0);
    check({tag, "_color_go"}, 32'(color_go), 0);
    check({tag, "_color_pos"}, 32'(color_pos), 0);
    check({tag, "_pending"}, 32'(pending), 0);
    check({tag, "_overflow"}, 32'(overflow), 0);
    check({tag, "_ack_err"}, 32'(ack_err), 0);
    check({tag, "_state"}, 32'(state_dbg), IDLE_CODE);
  endtask

  initial begin
    int lat;
    int n, s, exp_pend;
    logic [1:0] last_c;
    logic ovf_model;

    rst_n = 1'b0;
    mbed_go = 1'b0;
    mbed_color_stb = 1'b0;
    mbed_color = 2'd0;
    busy_drv = 1'b0;
    resp_en = 1'b0;
    resp_dur = 20;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // single token: go 8 edges after the first edge sampling mbed_go
    resp_en = 1'b1;
    resp_dur = 20;
    mbed_go = 1'b1;
    fork
      begin repeat (10) @(negedge clk); mbed_go = 1'b0; end
      begin @(posedge clk); edges_until(0, 30, lat); end
    join
    check("t1_latency", 32'(lat), DEB + 4);
    exp_q.push_back(3'b000);
    repeat (50) @(negedge clk);
    check("t1_pending", 32'(pending), 0);
    sb_drain("t1");

    // glitch reject, then a valid 5-cycle pulse
    resp_dur = 3;
    pulse_go(3, 10);
    check("t2_glitch_pending", 32'(pending), 0);
    check("t2_glitch_events", 32'(act_q.size()), 0);
    pulse_go(5, 30);
    exp_q.push_back(3'b000);
    sb_drain("t2");

    // queue and saturate while busy
    resp_en = 1'b0;
    busy_drv = 1'b1;
    repeat (5) pulse_go(6, 6);
    repeat (12) @(negedge clk);
    check("t3_pending_sat", 32'(pending), QMAX);
    check("t3_overflow", 32'(overflow), 1);
    repeat (QMAX) exp_q.push_back(3'b000);
    resp_dur = 2;
    resp_en = 1'b1;
    busy_drv = 1'b0;
    repeat (60) @(negedge clk);
    check("t3_pending_end", 32'(pending), 0);
    sb_drain("t3");

    // colour priority over queued tokens
    resp_en = 1'b0;
    busy_drv = 1'b1;
    repeat (2) pulse_go(6, 6);
    pulse_strobe(2'd2, 6, 12);
    check("t4_pending", 32'(pending), 2);
    busy_drv = 1'b0;
    resp_en = 1'b1;
    edges_until(1, 20, lat);
    check("t4_color_pos", 32'(color_pos), 2);
    edges_until(0, 30, lat);
    check("t4_go_gap", 32'(lat), SETTLE + 1);
    @(negedge clk);
    exp_q.push_back(3'b110);
    repeat (2) exp_q.push_back(3'b000);
    repeat (40) @(negedge clk);
    check("t4_pending_end", 32'(pending), 0);
    sb_drain("t4");

    // strobe-to-color_go latency from idle
    mbed_color = 2'd1;
    mbed_color_stb = 1'b1;
    fork
      begin repeat (6) @(negedge clk); mbed_color_stb = 1'b0; end
      begin @(posedge clk); edges_until(1, 30, lat); end
    join
    check("t4b_color_latency", 32'(lat), DEB + 4);
    exp_q.push_back(3'b101);
    repeat (20) @(negedge clk);
    sb_drain("t4b");

    // ack timeout: token dropped, next request still served
    resp_en = 1'b0;
    busy_drv = 1'b0;
    mbed_go = 1'b1;
    fork
      begin repeat (6) @(negedge clk); mbed_go = 1'b0; end
      begin
        @(posedge clk);
        edges_until(0, 30, lat);
        check("t5_go_latency", 32'(lat), DEB + 4);
        edges_until(2, 20, lat);
        check("t5_ack_latency", 32'(lat), ACK + 1);
      end
    join
    @(negedge clk);
    check("t5_pending", 32'(pending), 0);
    exp_q.push_back(3'b000);
    resp_en = 1'b1;
    pulse_go(6, 40);
    exp_q.push_back(3'b000);
    sb_drain("t5");
    check("t5_ack_err_sticky", 32'(ack_err), 1);
    check("t5_overflow_sticky", 32'(overflow), 1);

    // async reset while a token is in flight and two remain queued
    resp_en = 1'b0;
    busy_drv = 1'b1;
    repeat (3) pulse_go(6, 6);
    repeat (10) @(negedge clk);
    check("t6_pending_pre", 32'(pending), 3);
    busy_drv = 1'b0;
    edges_until(0, 20, lat);
    check("t6_go_issued", 32'(go), 1);
    @(negedge clk);
    busy_drv = 1'b1;
    exp_q.push_back(3'b000);
    repeat (5) @(negedge clk);
    check("t6_pending_mid", 32'(pending), 2);
    sb_drain("t6a");
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("t6_async");
    @(negedge clk);
    rst_n = 1'b1;
    busy_drv = 1'b0;
    repeat (30) @(negedge clk);
    check("t6_pending_post", 32'(pending), 0);
    sb_drain("t6b");

    // randomized rounds against the event-level model
    ovf_model = 1'b0;
    last_c = 2'd0;
    for (int r = 0; r < 8; r++) begin
      resp_en = 1'b0;
      busy_drv = 1'b1;
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) pulse_go($urandom_range(4, 8), $urandom_range(4, 8));
      s = $urandom_range(0, 2);
      for (int k = 0; k < s; k++) begin
        last_c = 2'($urandom_range(0, 3));
        pulse_strobe(last_c, $urandom_range(4, 8), $urandom_range(4, 8));
      end
      repeat (10) @(negedge clk);
      exp_pend = (n > QMAX) ? QMAX : n;
      if (n > QMAX) ovf_model = 1'b1;
      check("rnd_pending", 32'(pending), 32'(exp_pend));
      check("rnd_overflow", 32'(overflow), 32'(ovf_model));
      if (s > 0) exp_q.push_back({1'b1, last_c});
      repeat (exp_pend) exp_q.push_back(3'b000);
      resp_dur = $urandom_range(1, 4);
      resp_en = 1'b1;
      busy_drv = 1'b0;
      repeat (120) @(negedge clk);
      check("rnd_pending_end", 32'(pending), 0);
      check("rnd_ack_err", 32'(ack_err), 0);
      sb_drain("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
